// File: rtl/npu_pkg.sv
// Shared NPU word widths, default FIFO depth and word type.
package npu_pkg;

  localparam int unsigned NPU_WORD_W          = 32;
  localparam int unsigned NPU_CFG_W           = 26;
  localparam int unsigned NPU_FIFO_DEPTH_LOG2 = 4;

  typedef logic [NPU_WORD_W-1:0] npu_word_t;

endpackage

// File: rtl/npu_fifo_ram.sv
// 1-write / 1-async-read register array backing the NPU word FIFO.
// Ports: CLK clock; we/waddr/wdata write port; raddr/rdata async read port.
// No reset: contents are only observable after being written.
module npu_fifo_ram
  import npu_pkg::*;
#(
  parameter int unsigned WIDTH = NPU_WORD_W,
  parameter int unsigned AW    = NPU_FIFO_DEPTH_LOG2
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam int unsigned NENT = 1 << AW;

  logic [WIDTH-1:0] mem [NENT];

  // write port
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  // asynchronous read port
  assign rdata = mem[raddr];

endmodule

// File: rtl/npu_word_fifo.sv
// Synchronous first-word-fall-through word FIFO between the processor NPU
// port and the NPU core.
// Ports: CLK/RST (async active-high); wr_data/wr_en write side with full and
// almost_full; rd_en/rd_data read side with empty; count occupancy;
// clr_err clears sticky overflow/underflow flags.
module npu_word_fifo
  import npu_pkg::*;
#(
  parameter int unsigned WIDTH      = NPU_WORD_W,
  parameter int unsigned DEPTH_LOG2 = NPU_FIFO_DEPTH_LOG2,
  parameter int unsigned AF_LEVEL   = 12
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  input  logic                  clr_err,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned PW   = DEPTH_LOG2 + 1;
  localparam int unsigned NENT = 1 << DEPTH_LOG2;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    count_nxt;
  logic             wr_acc;
  logic             rd_acc;
  logic [WIDTH-1:0] ram_rdata;

  // acceptance uses this cycle's registered flags only
  always_comb begin
    wr_acc    = wr_en & ~full;
    rd_acc    = rd_en & ~empty;
    count_nxt = count + PW'(wr_acc) - PW'(rd_acc);
  end

  // pointers, occupancy, flow-control flags and sticky errors
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      count       <= count_nxt;
      full        <= (count_nxt == PW'(NENT));
      empty       <= (count_nxt == '0);
      almost_full <= (32'(count_nxt) >= AF_LEVEL);
      // set beats clear when both happen in the same cycle
      overflow    <= (wr_en & full)  | (overflow  & ~clr_err);
      underflow   <= (rd_en & empty) | (underflow & ~clr_err);
    end
  end

  npu_fifo_ram #(
    .WIDTH (WIDTH),
    .AW    (DEPTH_LOG2)
  ) u_ram (
    .CLK   (CLK),
    .we    (wr_acc),
    .waddr (wr_ptr[DEPTH_LOG2-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[DEPTH_LOG2-1:0]),
    .rdata (ram_rdata)
  );

  // stale array contents never leave the block while empty
  assign rd_data = empty ? '0 : ram_rdata;

endmodule

// File: doc/npu_word_fifo.md
# npu_word_fifo

Parameterised synchronous word FIFO that buffers 32-bit words between the Processor's NPU port and the NPU core. One instance sits on each processor-to-NPU path: input data, and config with `WIDTH=26`. A third instance sits on the NPU-to-processor output path. It provides the `full`/`empty` flow control the Processor samples, plus occupancy count and sticky error flags for debug.

## Interface
- `WIDTH`, 32: data word width in bits.
- `DEPTH_LOG2`, 4: log2 of entry count (16 entries by default).
- `AF_LEVEL`, 12: occupancy at or above which `almost_full` asserts.

- `CLK`  in  1  single clock; all state changes on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `wr_data`  in  WIDTH  word to enqueue.
- `wr_en`  in  1  enqueue request.
- `full`  out  1  no free entry; writes are ignored while high.
- `almost_full`  out  1  count >= AF_LEVEL.
- `rd_en`  in  1  dequeue request (pops the head word).
- `rd_data`  out  WIDTH  head word (first-word-fall-through).
- `empty`  out  1  no valid entry; reads are ignored while high.
- `count`  out  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2.
- `clr_err`  in  1  synchronous clear of the sticky error flags.
- `overflow`  out  1  sticky: a write was attempted while full.
- `underflow`  out  1  sticky: a read was attempted while empty.

## Operation
- Storage is a 2^DEPTH_LOG2 x WIDTH register array. Write and read pointers are DEPTH_LOG2+1 bits wide, so the extra MSB distinguishes full from empty.
- Write acceptance: `wr_acc = wr_en & ~full`. On an accepted write, mem[wr_ptr] <= wr_data and wr_ptr increments.
- Read acceptance: `rd_acc = rd_en & ~empty`. On an accepted read, rd_ptr increments.
- Both flags and the acceptance terms use the registered values of the current cycle.
- Pointer wrap: pointers wrap naturally modulo 2^(DEPTH_LOG2+1) with no special case.
- Count update per edge: `count <= count + wr_acc - rd_acc`.
- Flag update per edge:
  - `full <= (next count == 2^DEPTH_LOG2)`
  - `empty <= (next count == 0)`
  - `almost_full <= (next count >= AF_LEVEL)`
- Simultaneous read and write:
  - Not full and not empty: both are accepted; count, full and empty are unchanged; the head advances.
  - Full: the read is accepted and the write is rejected. `overflow` sets and count ends at 2^DEPTH_LOG2-1.
  - Empty: the write is accepted and the read is rejected. `underflow` sets, count ends at 1, and the new word appears on `rd_data` the next cycle.
- `rd_data` = mem[rd_ptr] when `empty`=0, and forced to 0 when `empty`=1. No X ever leaves the block.
- Sticky flags:
  - `overflow` sets on `wr_en & full`; `underflow` sets on `rd_en & empty`.
  - `clr_err` clears both flags. If a set condition and `clr_err` occur in the same cycle, set wins.
- Reset (asynchronous, any time, including mid-burst):
  - Pointers, count, `full`, `almost_full`, `overflow` and `underflow` go to 0.
  - `empty` goes to 1 and `rd_data` to 0.
  - Array contents are not cleared and are unobservable until rewritten.

## Timing
- Write-to-read latency: a word written at edge N is visible on `rd_data`, with `empty`=0, after edge N. It can be popped at edge N+1.
- Flags are registered: `full`, `empty`, `almost_full` and `count` reflect all transfers up to and including the last edge.
- No combinational path from `wr_en`/`rd_en` to any output.
- Throughput: one write and one read per cycle, sustained.
- Release of `RST` is synchronous to `CLK` (source: DCM LOCKED). The first transfer is possible on the first edge after deassertion.

## Structure
- Shared package `npu_pkg` holds:
  - `NPU_WORD_W=32` and `NPU_CFG_W=26`
  - the default `NPU_FIFO_DEPTH_LOG2=4`
  - typedef `npu_word_t`
- Sub-module `npu_fifo_ram`: 1-write/1-async-read register array with ports `CLK`, `we`, `waddr`, `wdata`, `raddr`, `rdata`. It has no reset.
- Pointer, count, flag and error logic live in `npu_word_fifo`.

## Test plan
- Reset then idle: after `RST` deasserts, `empty`=1, `full`=0, `count`=0, `rd_data`=0, `overflow`=0 and `underflow`=0.
- Fill and drain:
  - Write 0x00000001..0x00000010 on 16 consecutive cycles. Then `full`=1, `count`=16, and `almost_full` asserted from count 12 onward.
  - Read 16 words. They return in order 1..16, ending with `empty`=1.
- Full boundary:
  - With the FIFO full, write 0xDEADBEEF alone. It is dropped: `overflow`=1 and `count`=16.
  - Then read and write together. `rd_data` popped is 1, `count`=15 and 0xDEADBEEF is not stored. Pulse `clr_err` and `overflow` returns to 0.
- Empty boundary: with the FIFO empty, assert `rd_en` and `wr_en` (0xA5A5A5A5) together. `underflow`=1, `count`=1 and next-cycle `rd_data`=0xA5A5A5A5.
- Wrap and concurrency: 40 cycles of simultaneous write/read at `count`=5 with an incrementing pattern. `count` stays 5, data matches the reference queue, and both pointers wrap twice.
- Mid-operation reset: assert `RST` asynchronously between edges at `count`=9. Outputs go immediately to reset values, and a new write afterwards reads back correctly.
